// File: rtl/demux_pkg.sv
// demux_pkg
//   Shared constants and types for the registered 1-to-32 lane demultiplexer.
//   DATA_W : default sample width
//   LANES  : number of output lanes (fixed)
//   IDX_W  : width of the lane index
//   lane_t : one sample / one lane word
package demux_pkg;

  localparam int DATA_W = 16;
  localparam int LANES  = 32;
  localparam int IDX_W  = 5;

  typedef logic [DATA_W-1:0] lane_t;

endpackage

// File: rtl/demux_1_to_32_lane_shadow_bank.sv
// lane_shadow_bank
//   32-entry shadow register file that collects the lanes of the frame
//   currently being assembled. One indexed write port, all entries readable
//   in parallel so the output bank can load a whole frame on a single edge.
// Ports:
//   clk      : clock, all logic on posedge
//   rst      : synchronous active-high reset, clears every entry
//   we       : write enable
//   wr_idx   : entry written when we=1
//   wr_data  : data written when we=1
//   rd_data  : parallel read of all entries
module lane_shadow_bank
  import demux_pkg::*;
#(
  parameter int DATA_W = demux_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data [LANES]
);

  logic [DATA_W-1:0] mem [LANES];

  // Reset has priority over a write on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem;

endmodule

// File: rtl/demux_1_to_32.sv
// demux_1_to_32
//   Registered 1-to-32 lane demultiplexer. Serial samples are collected in a
//   shadow bank; when the 32nd sample of a frame is accepted the whole frame
//   is copied into the output bank on the same edge, so dout_* never mix
//   two frames. frame_valid pulses for one cycle after each load.
// Optional feature (macro DEMUX_SOF_EN): adds din_sof / frame_drop. An SOF
//   sample always becomes lane 0 and discards any partial frame, pulsing
//   frame_drop when something was actually discarded.
// Ports:
//   clk, rst            : clock / synchronous active-high reset
//   din, din_valid      : serial sample stream (no backpressure)
//   din_sof             : start-of-frame marker (DEMUX_SOF_EN only)
//   dout_0 .. dout_31   : registered frame lanes
//   frame_valid         : one-cycle pulse, dout_* just loaded
//   frame_drop          : one-cycle pulse, partial frame discarded (DEMUX_SOF_EN only)
//   wr_idx              : lane the next valid sample will fill
module demux_1_to_32
  import demux_pkg::*;
#(
  parameter int DATA_W = demux_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
`ifdef DEMUX_SOF_EN
  input  logic              din_sof,
  output logic              frame_drop,
`endif
  output logic [DATA_W-1:0] dout_0,
  output logic [DATA_W-1:0] dout_1,
  output logic [DATA_W-1:0] dout_2,
  output logic [DATA_W-1:0] dout_3,
  output logic [DATA_W-1:0] dout_4,
  output logic [DATA_W-1:0] dout_5,
  output logic [DATA_W-1:0] dout_6,
  output logic [DATA_W-1:0] dout_7,
  output logic [DATA_W-1:0] dout_8,
  output logic [DATA_W-1:0] dout_9,
  output logic [DATA_W-1:0] dout_10,
  output logic [DATA_W-1:0] dout_11,
  output logic [DATA_W-1:0] dout_12,
  output logic [DATA_W-1:0] dout_13,
  output logic [DATA_W-1:0] dout_14,
  output logic [DATA_W-1:0] dout_15,
  output logic [DATA_W-1:0] dout_16,
  output logic [DATA_W-1:0] dout_17,
  output logic [DATA_W-1:0] dout_18,
  output logic [DATA_W-1:0] dout_19,
  output logic [DATA_W-1:0] dout_20,
  output logic [DATA_W-1:0] dout_21,
  output logic [DATA_W-1:0] dout_22,
  output logic [DATA_W-1:0] dout_23,
  output logic [DATA_W-1:0] dout_24,
  output logic [DATA_W-1:0] dout_25,
  output logic [DATA_W-1:0] dout_26,
  output logic [DATA_W-1:0] dout_27,
  output logic [DATA_W-1:0] dout_28,
  output logic [DATA_W-1:0] dout_29,
  output logic [DATA_W-1:0] dout_30,
  output logic [DATA_W-1:0] dout_31,
  output logic              frame_valid,
  output logic [IDX_W-1:0]  wr_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  logic [DATA_W-1:0] shadow [LANES];
  logic [DATA_W-1:0] dout_q [LANES];
  logic              sof_hit;
  logic              frame_done;
  logic [IDX_W-1:0]  lane_sel;

`ifdef DEMUX_SOF_EN
  assign sof_hit = din_valid & din_sof;
`else
  assign sof_hit = 1'b0;
`endif

  // An SOF sample restarts the frame at lane 0 regardless of the count.
  assign lane_sel   = sof_hit ? '0 : wr_idx;
  assign frame_done = din_valid & ~sof_hit & (wr_idx == LAST_IDX);

  lane_shadow_bank #(
    .DATA_W (DATA_W)
  ) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .we      (din_valid),
    .wr_idx  (lane_sel),
    .wr_data (din),
    .rd_data (shadow)
  );

  // Lane counter, output bank and frame strobe. Lane 31 bypasses the shadow
  // bank because it is being written on the very edge that loads the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx      <= '0;
      frame_valid <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        dout_q[k] <= '0;
      end
    end else begin
      frame_valid <= frame_done;
      if (din_valid) begin
        wr_idx <= sof_hit ? IDX_W'(1) : wr_idx + IDX_W'(1);
      end
      if (frame_done) begin
        for (int k = 0; k < LANES - 1; k++) begin
          dout_q[k] <= shadow[k];
        end
        dout_q[LANES-1] <= din;
      end
    end
  end

`ifdef DEMUX_SOF_EN
  // A drop is only reported when an SOF interrupts a frame already underway.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_drop <= 1'b0;
    end else begin
      frame_drop <= sof_hit & (wr_idx != '0);
    end
  end
`endif

  assign dout_0  = dout_q[0];
  assign dout_1  = dout_q[1];
  assign dout_2  = dout_q[2];
  assign dout_3  = dout_q[3];
  assign dout_4  = dout_q[4];
  assign dout_5  = dout_q[5];
  assign dout_6  = dout_q[6];
  assign dout_7  = dout_q[7];
  assign dout_8  = dout_q[8];
  assign dout_9  = dout_q[9];
  assign dout_10 = dout_q[10];
  assign dout_11 = dout_q[11];
  assign dout_12 = dout_q[12];
  assign dout_13 = dout_q[13];
  assign dout_14 = dout_q[14];
  assign dout_15 = dout_q[15];
  assign dout_16 = dout_q[16];
  assign dout_17 = dout_q[17];
  assign dout_18 = dout_q[18];
  assign dout_19 = dout_q[19];
  assign dout_20 = dout_q[20];
  assign dout_21 = dout_q[21];
  assign dout_22 = dout_q[22];
  assign dout_23 = dout_q[23];
  assign dout_24 = dout_q[24];
  assign dout_25 = dout_q[25];
  assign dout_26 = dout_q[26];
  assign dout_27 = dout_q[27];
  assign dout_28 = dout_q[28];
  assign dout_29 = dout_q[29];
  assign dout_30 = dout_q[30];
  assign dout_31 = dout_q[31];

endmodule

// File: tb/tb_demux_1_to_32.sv
// tb_demux_1_to_32
//   Self-checking bench for demux_1_to_32. The reference model keeps the
//   samples of the frame being built in a queue; a frame is published when
//   the queue holds 32 samples. SOF scenarios are enabled with DEMUX_SOF_EN.
module tb_demux_1_to_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid;
  logic [15:0] din;
  logic [15:0] dout [32];
  logic        frame_valid;
  logic [4:0]  wr_idx;
`ifdef DEMUX_SOF_EN
  logic        din_sof;
  logic        frame_drop;
`endif

  // Reference model state
  logic [15:0] q [$];
  logic [15:0] exp_dout [32];
  logic        exp_fv;
  logic        exp_drop;
  int          fv_cycles [$];
  int          drop_count;
  int          cycle;
  int          tests;
  int          fails;

  always #5 clk = ~clk;

  demux_1_to_32 dut (
    .clk (clk), .rst (rst), .din (din), .din_valid (din_valid),
`ifdef DEMUX_SOF_EN
    .din_sof (din_sof), .frame_drop (frame_drop),
`endif
    .dout_0 (dout[0]),   .dout_1 (dout[1]),   .dout_2 (dout[2]),   .dout_3 (dout[3]),
    .dout_4 (dout[4]),   .dout_5 (dout[5]),   .dout_6 (dout[6]),   .dout_7 (dout[7]),
    .dout_8 (dout[8]),   .dout_9 (dout[9]),   .dout_10 (dout[10]), .dout_11 (dout[11]),
    .dout_12 (dout[12]), .dout_13 (dout[13]), .dout_14 (dout[14]), .dout_15 (dout[15]),
    .dout_16 (dout[16]), .dout_17 (dout[17]), .dout_18 (dout[18]), .dout_19 (dout[19]),
    .dout_20 (dout[20]), .dout_21 (dout[21]), .dout_22 (dout[22]), .dout_23 (dout[23]),
    .dout_24 (dout[24]), .dout_25 (dout[25]), .dout_26 (dout[26]), .dout_27 (dout[27]),
    .dout_28 (dout[28]), .dout_29 (dout[29]), .dout_30 (dout[30]), .dout_31 (dout[31]),
    .frame_valid (frame_valid),
    .wr_idx (wr_idx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Model update for one clock edge with the given inputs.
  task automatic modelStep(input logic r, input logic v, input logic s, input logic [15:0] d);
    exp_fv   = 1'b0;
    exp_drop = 1'b0;
    if (r) begin
      q.delete();
      for (int k = 0; k < 32; k++) exp_dout[k] = 16'h0;
    end else if (v) begin
`ifdef DEMUX_SOF_EN
      if (s) begin
        exp_drop = (q.size() != 0);
        q.delete();
      end
`else
      if (s) exp_drop = 1'b0;
`endif
      q.push_back(d);
      if (q.size() == 32) begin
        for (int k = 0; k < 32; k++) exp_dout[k] = q[k];
        exp_fv = 1'b1;
        q.delete();
      end
    end
  endtask

  task automatic checkOutput();
    int bad;
    bad = -1;
    check("wr_idx", {27'd0, wr_idx}, q.size());
    check("frame_valid", {31'd0, frame_valid}, {31'd0, exp_fv});
    for (int k = 31; k >= 0; k--) if (dout[k] !== exp_dout[k]) bad = k;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("[TB] FAIL dout lane %0d: got %h want %h (cycle %0d)", bad, dout[bad], exp_dout[bad], cycle);
    end
`ifdef DEMUX_SOF_EN
    check("frame_drop", {31'd0, frame_drop}, {31'd0, exp_drop});
    if (frame_drop === 1'b1) drop_count++;
`endif
    if (frame_valid === 1'b1) fv_cycles.push_back(cycle);
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic s, input logic [15:0] d);
    rst       = r;
    din_valid = v;
    din       = d;
`ifdef DEMUX_SOF_EN
    din_sof   = s;
`endif
    @(posedge clk);
    cycle++;
    modelStep(r, v, s, d);
    #1;
    checkOutput();
  endtask

  typedef struct {
    logic        rst;
    logic        valid;
    logic [15:0] din;
    logic [4:0]  exp_wr;
    logic        exp_fv;
  } vec_t;

  vec_t vecs [10];
  int   fv_before;

  initial begin
    tests = 0; fails = 0; cycle = 0; drop_count = 0;
    rst = 1'b1; din_valid = 1'b0; din = 16'h0;
`ifdef DEMUX_SOF_EN
    din_sof = 1'b0;
`endif
    for (int k = 0; k < 32; k++) exp_dout[k] = 16'h0;

    // Directed vectors: reset state and counting through gaps and a reset
    vecs[0] = '{1'b1, 1'b0, 16'h0000, 5'd0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 16'h0011, 5'd1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 16'h0022, 5'd1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 16'h0033, 5'd1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 16'h0044, 5'd2, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 16'h0055, 5'd3, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 16'h0066, 5'd0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 16'h0077, 5'd1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 16'h0088, 5'd1, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 16'h0000, 5'd0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, 1'b0, vecs[i].din);
      check("vec wr_idx", {27'd0, wr_idx}, {27'd0, vecs[i].exp_wr});
      check("vec frame_valid", {31'd0, frame_valid}, {31'd0, vecs[i].exp_fv});
    end

    // One contiguous frame
    fv_before = fv_cycles.size();
    for (int k = 0; k < 32; k++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0100 + 16'(k));
    check("frame1 lane31", {16'd0, dout[31]}, 32'h011F);
    check("frame1 lane0", {16'd0, dout[0]}, 32'h0100);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    check("frame1 pulses", fv_cycles.size() - fv_before, 1);

    // Same frame with 3-cycle gaps after every 5th sample
    fv_before = fv_cycles.size();
    for (int k = 0; k < 32; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0100 + 16'(k));
      if ((k % 5) == 4) for (int g = 0; g < 3; g++) applyStimulus(1'b0, 1'b0, 1'b0, 16'hDEAD);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    check("gap pulses", fv_cycles.size() - fv_before, 1);

    // Two back-to-back frames
    fv_before = fv_cycles.size();
    for (int k = 0; k < 32; k++) applyStimulus(1'b0, 1'b1, 1'b0, 16'hA000 + 16'(k));
    for (int k = 0; k < 32; k++) applyStimulus(1'b0, 1'b1, 1'b0, 16'hB000 + 16'(k));
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    check("b2b pulses", fv_cycles.size() - fv_before, 2);
    if (fv_cycles.size() >= 2)
      check("b2b spacing", fv_cycles[fv_cycles.size()-1] - fv_cycles[fv_cycles.size()-2], 32);
    check("b2b lane17", {16'd0, dout[17]}, 32'hB011);

    // Reset mid-frame
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h5500 + 16'(k));
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    check("rst lane5", {16'd0, dout[5]}, 32'h0);
    check("rst wr_idx", {27'd0, wr_idx}, 32'd0);
    fv_before = fv_cycles.size();
    for (int k = 0; k < 31; k++) applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFFF);
    check("rst early pulse", fv_cycles.size() - fv_before, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFFF);
    check("rst frame pulse", fv_cycles.size() - fv_before, 1);
    check("rst lane9", {16'd0, dout[9]}, 32'hFFFF);

`ifdef DEMUX_SOF_EN
    // SOF resync after 12 samples
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    drop_count = 0;
    fv_before  = fv_cycles.size();
    for (int k = 0; k < 12; k++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h7700 + 16'(k));
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234);
    for (int k = 1; k < 32; k++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h2200 + 16'(k));
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    check("sof drops", drop_count, 1);
    check("sof pulses", fv_cycles.size() - fv_before, 1);
    check("sof lane0", {16'd0, dout[0]}, 32'h1234);
    check("sof lane11", {16'd0, dout[11]}, 32'h220B);

    // SOF without valid is ignored
    for (int k = 0; k < 7; k++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h3300 + 16'(k));
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h9999);
    check("sof idle wr_idx", {27'd0, wr_idx}, 32'd7);
    check("sof idle drop", {31'd0, frame_drop}, 32'd0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 39) == 0), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux_1_to_32.md
# demux_1_to_32

Registered 1-to-32 lane demultiplexer: accepts a serial stream of 16-bit samples on one port and distributes 32 consecutive valid samples onto 32 parallel output lanes. The 32 lanes are presented as a single coherent frame with a one-cycle strobe. It sits in the D_CFIR datapath as the fan-out counterpart of the registered 32-to-1 lane mux. It rebuilds a parallel lane set from a time-multiplexed coefficient/sample stream.

## Interface
Parameters:
- DATA_W, 16, sample width. The lane count is fixed at 32.

Ports:
- clk  input  1  single clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- din  input  DATA_W  serial sample
- din_valid  input  1  din valid this cycle
- din_sof  input  1  start-of-frame marker, qualified by din_valid (present only with DEMUX_SOF_EN)
- dout_0 … dout_31  output  DATA_W each  frame lanes, registered
- frame_valid  output  1  one-cycle pulse: dout_* just updated with a complete frame
- frame_drop  output  1  one-cycle pulse: partial frame discarded by resync (present only with DEMUX_SOF_EN)
- wr_idx  output  5  lane index the next valid sample will fill

## Operation
- wr_idx counts accepted samples 0..31 and wraps 31 → 0. It advances only when din_valid=1.
- An accepted sample with wr_idx=k is written into shadow register k.
- When the sample with wr_idx=31 is accepted, the output bank is loaded on the same edge:
  - dout_0..dout_30 take shadow 0..30.
  - dout_31 takes din directly.
  - frame_valid is set.
- dout_* hold between frames and never show a mix of two frames.
- Gaps (din_valid=0) of any length are allowed mid-frame. State holds during a gap.
- No backpressure. The downstream consumer must sample dout_* within 32 valid cycles of frame_valid.
- Reset values:
  - wr_idx=0, all shadow=0, all dout_*=0
  - frame_valid=0, frame_drop=0
- Reset mid-frame discards the partial frame. dout_* clear to 0.
- Width rule: no arithmetic on data; din is stored bit-exact.

## Timing
- Latency: edge accepting lane-31 sample → dout_* and frame_valid visible in the following cycle.
- frame_valid is high for exactly one cycle per complete frame. The minimum spacing is 32 cycles.
- rst has priority over din_valid and din_sof on the same edge.
- wr_idx is a registered output, updated on the accepting edge.

## Configuration
- DEMUX_SOF_EN defined:
  - The din_sof and frame_drop ports exist.
  - A sample with din_valid=1 and din_sof=1 is always written as lane 0, and wr_idx becomes 1.
  - If wr_idx≠0 at that edge, the in-progress frame is discarded, dout_* are untouched, and frame_drop pulses for one cycle in the following cycle.
  - If wr_idx=0, no drop is signalled.
  - din_sof with din_valid=0 is ignored.
- DEMUX_SOF_EN undefined:
  - Neither port exists.
  - Framing is purely by count from reset. The first 32 valid samples after reset form frame 0.

## Structure
- Shared package demux_pkg holds:
  - DATA_W default (16)
  - LANES=32
  - IDX_W=5
  - the typedef lane_t = logic [DATA_W-1:0]
- One sub-module, lane_shadow_bank, is natural:
  - It contains the 32-entry shadow register file with index write-enable and a parallel read of all entries.
  - The top level holds wr_idx, the output bank, the strobes and the SOF logic.

## Test plan
- Reset, then 32 consecutive valid samples din=16'h0100+k for k=0..31 → one cycle after the 32nd edge, dout_k=16'h0100+k for all k, frame_valid=1 for one cycle, wr_idx=0.
- Same 32 samples with din_valid deasserted for 3 cycles after every 5th sample → identical dout_* and a single frame_valid. dout_* hold their previous value through the whole frame.
- Two back-to-back frames (values 16'hA000+k, then 16'hB000+k) → frame_valid pulses exactly 32 cycles apart. After the second pulse, all lanes read 16'hB000+k with no mixing.
- 10 valid samples, then rst=1 for 1 cycle, then 32 samples of 16'hFFFF → after reset, dout_*=0 and wr_idx=0. The next frame_valid occurs only after all 32 new samples, with all lanes at 16'hFFFF.
- (DEMUX_SOF_EN) 12 valid samples, then din_sof=1 with din=16'h1234, then 31 more samples → frame_drop pulses once. A single frame_valid follows with dout_0=16'h1234, and the earlier 12 samples do not appear.
- (DEMUX_SOF_EN) din_sof=1 with din_valid=0 at wr_idx=7 → wr_idx stays 7, frame_drop stays 0.
